// File: rtl/plb_cache_responder_pkg.sv
// Shared types for the PLB cache responder.
// Lookup key, response byte layout and fill checks.
package plb_cache_responder_pkg;

  typedef struct packed {
    logic [3:0]  sid;
    logic [15:0] page;
  } plb_lookup_req_t;

  localparam int PLB_ADDR_W = $bits(plb_lookup_req_t);
  localparam int PLB_ENTRIES_DEFAULT = 8;

  localparam int PLB_PERM_R = 2;
  localparam int PLB_PERM_W = 1;
  localparam int PLB_PERM_X = 0;

  typedef struct packed {
    logic [3:0] rsvd;
    logic [2:0] perm;
    logic       hit;
  } plb_resp_t;

  // Fill byte carries {r,w,x} in [3:1]; all else must be zero.
  function automatic logic fill_bad(
    input logic [7:0] d
  );
    return (|d[7:4]) | d[0];
  endfunction

endpackage

// File: rtl/plb_cache_responder_if.sv
// PLB cache memory port between walker (master)
// and the responder (slave).
interface plb_cache_responder_if
  import plb_cache_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = PLB_ADDR_W
) ();

  logic                  req;
  logic                  gnt;
  logic                  valid;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            rdata;
  logic [7:0]            wdata;
  logic                  we;
  logic                  be;
  logic                  error;

  modport master (
    output req, addr, wdata, we, be,
    input  gnt, valid, rdata, error
  );

  modport slave (
    input  req, addr, wdata, we, be,
    output gnt, valid, rdata, error
  );

endinterface

// File: rtl/plb_cache_responder_victim_sel.sv
// Victim choice: lowest free entry, else the
// round-robin pointer.
module plb_cache_responder_victim_sel #(
  parameter int ENTRIES = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [ENTRIES-1:0]         valid_i,
  input  logic                       advance_i,
  output logic [$clog2(ENTRIES)-1:0] victim_o,
  output logic                       full_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] free_idx;
  logic             any_free;

  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (flush_i)
      ptr_d = '0;
    else if (advance_i)
      ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign victim_o = any_free ? free_idx : ptr_q;
  assign full_o   = ~any_free;

endmodule

// File: rtl/plb_cache_responder.sv
// Fully-associative PLB serving the walker's
// plb_cache_mem port: lookups and fills.
module plb_cache_responder
  import plb_cache_responder_pkg::*;
#(
  parameter int ENTRIES    = PLB_ENTRIES_DEFAULT,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = PLB_ADDR_W
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  plb_cache_responder_if.slave plb_cache_mem
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0]    vld_q;
  logic [ADDR_WIDTH-1:0] tag_q  [ENTRIES];
  logic [2:0]            perm_q [ENTRIES];

  logic                  valid_q;
  logic                  error_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  gnt, err, wr_ok;
  logic                  hit, full, advance;
  logic [ENTRIES-1:0]    hit_vec;
  logic [IDX_W-1:0]      hit_idx, victim;
  logic [2:0]            hit_perm, fill_perm;
  plb_resp_t             resp;

  always_comb begin
    gnt = plb_cache_mem.req & ~flush_i & rst_ni;
    err = ~plb_cache_mem.be
        | (plb_cache_mem.we
           & fill_bad(plb_cache_mem.wdata));
    wr_ok = gnt & plb_cache_mem.we & ~err;
  end

  always_comb begin
    fill_perm = '0;
    fill_perm[PLB_PERM_R] = plb_cache_mem.wdata[3];
    fill_perm[PLB_PERM_W] = plb_cache_mem.wdata[2];
    fill_perm[PLB_PERM_X] = plb_cache_mem.wdata[1];
  end

  // Tags are unique, so OR-reducing the hit lane is exact.
  always_comb begin
    hit_vec  = '0;
    hit_idx  = '0;
    hit_perm = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      hit_vec[i] = vld_q[i]
                 & (tag_q[i] == plb_cache_mem.addr);
      if (hit_vec[i]) begin
        hit_idx  = hit_idx | IDX_W'(i);
        hit_perm = hit_perm | perm_q[i];
      end
    end
    hit = |hit_vec;
  end

  always_comb begin
    resp      = '0;
    resp.perm = hit_perm;
    resp.hit  = 1'b1;
    rdata_d   = '0;
    if (gnt & ~plb_cache_mem.we & ~err & hit)
      rdata_d = resp;
    advance = wr_ok & ~hit & full;
  end

  plb_cache_responder_victim_sel #(
    .ENTRIES (ENTRIES)
  ) u_victim (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .valid_i   (vld_q),
    .advance_i (advance),
    .victim_o  (victim),
    .full_o    (full)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      valid_q <= gnt;
      rdata_q <= rdata_d;
      error_q <= gnt & err;
      if (flush_i)
        vld_q <= '0;
      else if (wr_ok & ~hit)
        vld_q[victim] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      if (hit) begin
        perm_q[hit_idx] <= fill_perm;
      end else begin
        tag_q[victim]  <= plb_cache_mem.addr;
        perm_q[victim] <= fill_perm;
      end
    end
  end

  assign plb_cache_mem.gnt   = gnt;
  assign plb_cache_mem.valid = valid_q;
  assign plb_cache_mem.rdata = rdata_q;
  assign plb_cache_mem.error = error_q;

endmodule

// File: tb/tb_plb_cache_responder.sv
// Directed table bench for plb_cache_responder:
// fill, update, eviction, flush, errors, reset.
module tb_plb_cache_responder;
  import plb_cache_responder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  plb_cache_responder_if bus ();

  plb_cache_responder u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .plb_cache_mem (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        rq;
    logic        we;
    logic        be;
    logic [19:0] a;
    logic [7:0]  wd;
    logic        g;
    logic [7:0]  rd;
    logic        e;
  } vec_t;

  vec_t vq[$];
  int   nvec;
  int   fails;

  function automatic logic [19:0] tg(input int i);
    return 20'h3A000 + 20'(i * 37);
  endfunction

  task automatic add(
    input logic fl, rq, we, be,
    input logic [19:0] a,
    input logic [7:0] wd,
    input logic g,
    input logic [7:0] rd,
    input logic e
  );
    vec_t v;
    v.fl = fl; v.rq = rq; v.we = we; v.be = be;
    v.a = a; v.wd = wd; v.g = g; v.rd = rd; v.e = e;
    vq.push_back(v);
  endtask

  task automatic wr(
    input logic [19:0] a,
    input logic [7:0] d,
    input logic e
  );
    add(0, 1, 1, 1, a, d, 1, 8'h00, e);
  endtask

  task automatic rd(
    input logic [19:0] a,
    input logic [7:0] x
  );
    add(0, 1, 0, 1, a, 8'h00, 1, x, 0);
  endtask

  task automatic fl(
    input logic rq,
    input logic [19:0] a
  );
    add(1, rq, 0, 1, a, 8'h00, 0, 8'h00, 0);
  endtask

  task automatic apply(input vec_t v);
    flush     = v.fl;
    bus.req   = v.rq;
    bus.we    = v.we;
    bus.be    = v.be;
    bus.addr  = v.a;
    bus.wdata = v.wd;
  endtask

  task automatic chk(
    input string nm,
    input int idx,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0d: got %h, expected %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic chk_resp(
    input int idx,
    input logic v,
    input logic [7:0] r,
    input logic e
  );
    chk("valid", idx, 8'(bus.valid), 8'(v));
    chk("rdata", idx, bus.rdata, r);
    chk("error", idx, 8'(bus.error), 8'(e));
  endtask

  initial begin
    vec_t idle, cur, prv;
    idle = '{default: '0};
    nvec  = 0;
    fails = 0;

    // T1: reset held with req asserted
    rst_n = 1'b0;
    apply(idle);
    bus.req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #4;
      chk("rst_gnt", c, 8'(bus.gnt), 8'h00);
      chk_resp(c, 1'b0, 8'h00, 1'b0);
      nvec++;
    end
    bus.req = 1'b0;
    rst_n   = 1'b1;

    // T2: fill then hit / miss
    wr(tg(100), 8'h0E, 0);
    rd(tg(100), 8'h0F);
    rd(tg(101), 8'h00);
    // T3/T4: update in place, eviction, wrap
    fl(0, 20'h0);
    wr(tg(0), 8'h02, 0);
    wr(tg(0), 8'h08, 0);
    rd(tg(0), 8'h09);
    for (int i = 1; i < 8; i++)
      wr(tg(i), 8'h0E, 0);
    wr(tg(8), 8'h04, 0);
    rd(tg(0), 8'h00);
    rd(tg(8), 8'h05);
    rd(tg(1), 8'h0F);
    wr(tg(9), 8'h06, 0);
    rd(tg(1), 8'h00);
    rd(tg(9), 8'h07);
    for (int i = 10; i < 16; i++)
      wr(tg(i), 8'h02, 0);
    wr(tg(16), 8'h0A, 0);
    rd(tg(8), 8'h00);
    rd(tg(9), 8'h07);
    rd(tg(16), 8'h0B);
    rd(tg(15), 8'h03);
    // T5: flush against a request
    rd(tg(9), 8'h07);
    fl(1, tg(9));
    rd(tg(9), 8'h00);
    // T6: errors and back-to-back reads
    wr(tg(102), 8'h0E, 0);
    wr(tg(102), 8'h1E, 1);
    rd(tg(102), 8'h0F);
    wr(tg(102), 8'h0F, 1);
    add(0, 1, 1, 0, tg(102), 8'h02, 1, 8'h00, 1);
    add(0, 1, 0, 0, tg(102), 8'h00, 1, 8'h00, 1);
    rd(tg(102), 8'h0F);
    wr(tg(20), 8'h02, 0);
    wr(tg(21), 8'h04, 0);
    wr(tg(22), 8'h08, 0);
    rd(tg(102), 8'h0F);
    rd(tg(20), 8'h03);
    rd(tg(21), 8'h05);
    rd(tg(22), 8'h09);

    for (int i = 0; i <= vq.size(); i++) begin
      cur = (i < vq.size()) ? vq[i] : idle;
      @(posedge clk);
      #1;
      apply(cur);
      #3;
      if (i < vq.size()) begin
        chk("gnt", i, 8'(bus.gnt), 8'(cur.g));
        nvec++;
      end
      if (i > 0) begin
        prv = vq[i-1];
        chk_resp(i, prv.g, prv.rd, prv.e);
      end
    end

    // Reset arriving while a response is on the bus
    @(posedge clk);
    #1;
    cur = idle;
    cur.rq = 1'b1; cur.be = 1'b1; cur.a = tg(20);
    apply(cur);
    #3;
    chk("mid_gnt", 0, 8'(bus.gnt), 8'h01);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #3;
    chk("mid_rgnt", 1, 8'(bus.gnt), 8'h00);
    chk_resp(1, 1'b1, 8'h03, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    chk_resp(2, 1'b0, 8'h00, 1'b0);
    chk("post_gnt", 2, 8'(bus.gnt), 8'h01);
    @(posedge clk);
    #1;
    apply(idle);
    #3;
    chk_resp(3, 1'b1, 8'h00, 1'b0);
    nvec += 4;

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, fails);
    $finish;
  end

endmodule
